// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: word type and FSM state encoding.
package dmem_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of the data-memory arbiter; requester i uses slice [16i+15:16i].
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*WORD_W-1:0] req_addr;
    logic [NREQ*WORD_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    word_t                  rsp_rdata;
    logic [NREQ-1:0]        rsp_ready;
    logic                   mem_en;
    logic                   mem_we;
    word_t                  mem_addr;
    word_t                  mem_wdata;
    word_t                  mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester found scanning upward from last+1.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one 64K x 16 data memory; one transaction in flight,
// IDLE -> ISSUE -> WAIT -> RESP with valid/ready on both request and response sides.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus,
    output logic          busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            we_q, we_d;
    word_t           addr_q, addr_d;
    word_t           wdata_q, wdata_d;
    word_t           rdata_q, rdata_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (bus.req_valid),
        .last (last_q),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            last_q  <= IW'(NREQ - 1);
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    state_d = ARB_ISSUE;
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    // Only the winner's slot is sampled, so idle slots may carry anything.
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            we_d    = bus.req_we[i];
                            addr_d  = bus.req_addr[WORD_W*i +: WORD_W];
                            wdata_d = bus.req_wdata[WORD_W*i +: WORD_W];
                        end
                    end
                end
            end
            ARB_ISSUE: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (bus.rsp_ready[owner_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant is combinational in IDLE; held off while reset is asserted.
    assign bus.req_ready = (state_q == ARB_IDLE && !reset) ? gnt : '0;
    assign bus.mem_en    = (state_q == ARB_ISSUE);
    assign bus.mem_we    = (state_q == ARB_ISSUE) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == ARB_RESP) ? (NREQ'(1) << owner_q) : '0;
    assign bus.rsp_rdata = rdata_q;
    assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timeline reference model on a 3-requester,
// latency-1 instance plus a latency-3 instance for the read-latency case.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int NA = 3;
    localparam int LA = 1;
    localparam int NB = 2;
    localparam int LB = 3;

    logic clk = 1'b0;
    logic reset;
    logic busy_a, busy_b;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NREQ(NA)) ifa ();
    dmem_arbiter_if #(.NREQ(NB)) ifb ();

    dmem_arbiter #(.NREQ(NA), .MEM_LAT(LA)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave), .busy(busy_a)
    );

    dmem_arbiter #(.NREQ(NB), .MEM_LAT(LB)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memories: A answers one cycle after mem_en, B three cycles after mem_en.
    logic [15:0] mem_a [65536];
    logic [15:0] mem_b [65536];
    logic [15:0] mem_ref [65536];
    logic [15:0] rd_a;
    logic [15:0] pb [LB];

    always @(posedge clk) begin
        if (ifa.mem_en) begin
            if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
            rd_a <= mem_a[ifa.mem_addr];
        end
    end
    assign ifa.mem_rdata = rd_a;

    always @(posedge clk) begin
        if (ifb.mem_en && ifb.mem_we) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
        pb[0] <= ifb.mem_en ? mem_b[ifb.mem_addr] : 16'hDEAD;
        for (int s = 1; s < LB; s++) pb[s] <= pb[s-1];
    end
    assign ifb.mem_rdata = pb[LB-1];

    // Reference model for instance A: tracks the accepted transaction by its age in cycles.
    bit              m_pending;
    int              m_age, m_owner, m_last;
    bit              m_we;
    logic [15:0]     m_addr, m_wdata, m_exp;
    logic [NA-1:0]   m_acc;
    logic [NA-1:0]   exp_ready;
    int              w_e;
    bit              resp_e;
    int              n_acc = 0;
    int              n_mem_en_a = 0;
    int              n_mem_en_b = 0;
    int              n_gnt_a [NA];

    always @(negedge clk) begin
        if (ifa.mem_en) n_mem_en_a++;
        if (ifb.mem_en) n_mem_en_b++;
        for (int i = 0; i < NA; i++) if (ifa.req_ready[i]) n_gnt_a[i]++;
        if (reset) begin
            chk("rst_req_ready", ifa.req_ready, 0);
            chk("rst_rsp_valid", ifa.rsp_valid, 0);
            chk("rst_rsp_rdata", ifa.rsp_rdata, 0);
            chk("rst_mem_en",    ifa.mem_en, 0);
            chk("rst_mem_we",    ifa.mem_we, 0);
            chk("rst_mem_addr",  ifa.mem_addr, 0);
            chk("rst_mem_wdata", ifa.mem_wdata, 0);
            chk("rst_busy",      busy_a, 0);
            m_pending = 1'b0;
            m_last    = NA - 1;
            m_acc     = '0;
        end else begin
            w_e = -1;
            if (!m_pending)
                for (int k = 1; k <= NA; k++)
                    if (w_e < 0 && ifa.req_valid[(m_last + k) % NA]) w_e = (m_last + k) % NA;
            exp_ready = (w_e >= 0) ? (NA'(1) << w_e) : NA'(0);
            m_acc     = exp_ready;
            chk("req_ready", ifa.req_ready, exp_ready);
            chk("busy", busy_a, m_pending);
            chk("mem_en", ifa.mem_en, m_pending && m_age == 1);
            if (m_pending && m_age == 1) begin
                chk("mem_we",    ifa.mem_we, m_we);
                chk("mem_addr",  ifa.mem_addr, m_addr);
                chk("mem_wdata", ifa.mem_wdata, m_wdata);
                if (m_we) mem_ref[m_addr] = m_wdata;
            end
            resp_e = m_pending && m_age >= LA + 2;
            chk("rsp_valid", ifa.rsp_valid, resp_e ? (NA'(1) << m_owner) : NA'(0));
            if (resp_e) chk("rsp_rdata", ifa.rsp_rdata, m_exp);
            if (w_e >= 0) begin
                m_pending = 1'b1;
                m_age     = 1;
                m_owner   = w_e;
                m_last    = w_e;
                m_we      = ifa.req_we[w_e];
                m_addr    = ifa.req_addr[16*w_e +: 16];
                m_wdata   = ifa.req_wdata[16*w_e +: 16];
                m_exp     = m_we ? 16'h0000 : mem_ref[m_addr];
                n_acc++;
            end else if (m_pending) begin
                if (resp_e) begin
                    if (ifa.rsp_ready[m_owner]) m_pending = 1'b0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // Watchdog so the run ends even if the design never goes idle.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, busy_a=%0b required 0", busy_a);
        $fatal(1, "watchdog expired");
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit we, input logic [15:0] a, input logic [15:0] d);
        ifa.req_valid[i]        = 1'b1;
        ifa.req_we[i]           = we;
        ifa.req_addr[16*i +: 16]  = a;
        ifa.req_wdata[16*i +: 16] = d;
    endtask

    task automatic wait_acc(input int i, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifa.req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_accept"}, got, 1);
        drive_pt();
        ifa.req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input string tag, output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 16'h0;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (ifa.rsp_valid[i]) begin
                lat = k;
                rd  = ifa.rsp_rdata;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, lat > 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy_a) break;
        end
        chk({tag, "_idle"}, busy_a, 0);
    endtask

    function automatic bit rnd_bit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h0010;
            2:       return 16'hFFFF;
            default: return 16'($urandom_range(0, 7));
        endcase
    endfunction

    int          lat;
    logic [15:0] rd;
    int          g, base_m, base_g1, base_b;
    bit          got;

    initial begin
        reset = 1'b1;
        for (int a = 0; a < 65536; a++) begin
            mem_a[a]   <= 16'(a) ^ 16'h5A5A;
            mem_ref[a]  = 16'(a) ^ 16'h5A5A;
            mem_b[a]   <= ~16'(a);
        end
        mem_b[16'hFFFF] <= 16'h1234;
        rd_a            <= 16'h0;
        for (int i = 0; i < NA; i++) n_gnt_a[i] = 0;
        ifa.req_valid = '0; ifa.req_we = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifa.rsp_ready = '1;
        ifb.req_valid = '0; ifb.req_we = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        ifb.rsp_ready = '1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Contention from reset: requester 0 first, then strict alternation.
        set_req(0, 1'b0, 16'h0020, 16'h0);
        set_req(1, 1'b0, 16'h0021, 16'h0);
        g = 0;
        for (int k = 0; k < 200 && g < 6; k++) begin
            @(negedge clk);
            if (ifa.req_ready != '0) begin
                chk("t2_grant", ifa.req_ready, (g % 2 == 0) ? 3'b001 : 3'b010);
                g++;
            end
        end
        chk("t2_grant_count", g, 6);
        drive_pt();
        ifa.req_valid = '0;
        wait_idle("t2");

        // Store then load on requester 0.
        drive_pt();
        set_req(0, 1'b1, 16'h0010, 16'hBEEF);
        wait_acc(0, "t1_st");
        wait_rsp(0, "t1_st", lat, rd);
        chk("t1_st_lat", lat, 3);
        chk("t1_st_rdata", rd, 16'h0000);
        drive_pt();
        set_req(0, 1'b0, 16'h0010, 16'h0);
        wait_acc(0, "t1_ld");
        wait_rsp(0, "t1_ld", lat, rd);
        chk("t1_ld_lat", lat, 3);
        chk("t1_ld_rdata", rd, 16'hBEEF);

        // Back-pressure on requester 1 while requester 0 waits.
        drive_pt();
        ifa.rsp_ready = 3'b101;
        set_req(1, 1'b0, 16'h0010, 16'h0);
        wait_acc(1, "t3");
        set_req(0, 1'b0, 16'h0020, 16'h0);
        wait_rsp(1, "t3", lat, rd);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_rsp_valid", ifa.rsp_valid, 3'b010);
            chk("t3_rsp_rdata", ifa.rsp_rdata, 16'hBEEF);
            chk("t3_req_ready0", ifa.req_ready[0], 0);
            chk("t3_mem_en", ifa.mem_en, 0);
        end
        drive_pt();
        ifa.rsp_ready = '1;
        wait_acc(0, "t3b");
        wait_idle("t3");

        // Withdrawn request: one-cycle pulse on requester 1 while busy.
        drive_pt();
        base_m  = n_mem_en_a;
        base_g1 = n_gnt_a[1];
        set_req(0, 1'b0, 16'h0030, 16'h0);
        wait_acc(0, "t6");
        set_req(1, 1'b1, 16'h0040, 16'h7777);
        drive_pt();
        ifa.req_valid[1] = 1'b0;
        wait_idle("t6");
        repeat (3) @(negedge clk);
        chk("t6_mem_en_count", n_mem_en_a - base_m, 1);
        chk("t6_gnt1_count", n_gnt_a[1] - base_g1, 0);

        // Reset while waiting on memory, then normal operation with requester 0 first.
        drive_pt();
        set_req(0, 1'b0, 16'h0010, 16'h0);
        wait_acc(0, "t5_pre");
        drive_pt();
        chk("t5_in_wait_busy", busy_a, 1);
        reset = 1'b1;
        #1;
        chk("t5_busy", busy_a, 0);
        chk("t5_mem_en", ifa.mem_en, 0);
        chk("t5_rsp_valid", ifa.rsp_valid, 0);
        chk("t5_rsp_rdata", ifa.rsp_rdata, 0);
        drive_pt();
        drive_pt();
        reset = 1'b0;
        set_req(0, 1'b1, 16'h0000, 16'h0001);
        set_req(1, 1'b0, 16'h0010, 16'h0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifa.req_ready != '0) begin
                got = 1'b1;
                break;
            end
        end
        chk("t5_first_gnt", ifa.req_ready, 3'b001);
        drive_pt();
        ifa.req_valid[0] = 1'b0;
        wait_rsp(0, "t5", lat, rd);
        chk("t5_lat", lat, 3);
        chk("t5_st_rdata", rd, 0);
        wait_acc(1, "t5b");
        wait_idle("t5");
        chk("t5_mem0", mem_a[0], 16'h0001);

        // Latency-3 instance: load of the last address.
        drive_pt();
        base_b = n_mem_en_b;
        ifb.req_valid[0]      = 1'b1;
        ifb.req_we[0]         = 1'b0;
        ifb.req_addr[15:0]    = 16'hFFFF;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifb.req_ready[0]) begin
                got = 1'b1;
                break;
            end
        end
        chk("t4_accept", got, 1);
        drive_pt();
        ifb.req_valid[0] = 1'b0;
        lat = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (ifb.rsp_valid != '0) begin
                lat = k;
                chk("t4_rsp_valid", ifb.rsp_valid, 2'b01);
                chk("t4_rdata", ifb.rsp_rdata, 16'h1234);
                break;
            end
        end
        chk("t4_lat", lat, 5);
        repeat (3) @(negedge clk);
        chk("t4_mem_en_count", n_mem_en_b - base_b, 1);
        chk("t4_idle", busy_b, 0);

        // Randomized traffic against the reference model.
        base_m = n_acc;
        for (int c = 0; c < 3000; c++) begin
            drive_pt();
            for (int i = 0; i < NA; i++) begin
                if (ifa.req_valid[i] && m_acc[i]) begin
                    if (rnd_bit()) set_req(i, rnd_bit(), pick_addr(), 16'($urandom));
                    else ifa.req_valid[i] = 1'b0;
                end else if (ifa.req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) ifa.req_valid[i] = 1'b0;
                end else begin
                    ifa.req_we[i]           = rnd_bit();
                    ifa.req_addr[16*i +: 16]  = 16'($urandom);
                    ifa.req_wdata[16*i +: 16] = 16'($urandom);
                    if ($urandom_range(0, 2) == 0) set_req(i, rnd_bit(), pick_addr(), 16'($urandom));
                end
                ifa.rsp_ready[i] = ($urandom_range(0, 9) < 7);
            end
        end
        drive_pt();
        ifa.req_valid = '0;
        ifa.rsp_ready = '1;
        wait_idle("rand");
        chk("rand_activity", (n_acc - base_m) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
